// File: rtl/joy_db9md_scan.sv
// Purpose: DB9 Megadrive splitter scan scheduler; drives TH/select and the port
//          mux, samples joy_in, classifies pads and publishes atomic snapshots.
// Latency: pin to snapshot <= one frame period + 3 clk (2-flop sync + publish stage).
// Backpressure: none; scan_en only gates the start of the next frame.
// Option:  define JOY_DB9MD_6BTN_EN for the 8-phase sequence with 6-button
//          detection; undefined runs P0..P3 only, with M/X/Y/Z tied low.
module joy_db9md_scan #(
  parameter int SLOT_CYCLES = 256,
  parameter int IDLE_PHASES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scan_en,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic [1:0]  joy1_type,
  output logic [1:0]  joy2_type,
  output logic        frame_done
);

  // Counter widths; guarded so degenerate parameters still give 1-bit vectors.
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (IDLE_PHASES > 0) ? $clog2(IDLE_PHASES + 1) : 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_PHASES > 0) ? IDLE_PHASES - 1 : 0);

`ifdef JOY_DB9MD_6BTN_EN
  localparam logic [2:0] LAST_PHASE = 3'd7;
`else
  localparam logic [2:0] LAST_PHASE = 3'd3;
`endif

  // Scheduler states
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Sequencer state
  logic [1:0]    state;
  logic [2:0]    phase;
  logic          half;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] slot_cnt;
  logic          pub_pending;

  // Next-state values, applied only at a half-slot boundary
  logic [1:0]    nxt_state;
  logic [2:0]    nxt_phase;
  logic          nxt_half;
  logic [IW-1:0] nxt_idle;
  logic          frame_end;
  logic          nxt_mdsel;
  logic          nxt_split;

  // Synchronizer
  logic [5:0] joy_s1;
  logic [5:0] joy_s2;

  // Per-port working registers (button vector in output order, type flags)
  logic [11:0] w1_btn;
  logic [11:0] w2_btn;
  logic        w1_md;
  logic        w2_md;
  logic        w1_6b;
  logic        w2_6b;

  // Update path for whichever port the current half-slot is sampling
  logic [11:0] cur_btn;
  logic        cur_md;
  logic        cur_6b;
  logic [11:0] new_btn;
  logic        new_md;
  logic        new_6b;

  logic slot_end;
  logic sample;

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign sample   = slot_end && (state == ST_ACTIVE);

  // Two-flop synchronizer for the asynchronous pin bus (idles released = high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_s1 <= 6'h3F;
      joy_s2 <= 6'h3F;
    end else begin
      joy_s1 <= joy_in;
      joy_s2 <= joy_s1;
    end
  end

  // Next phase/half/idle position and the pin levels that go with it
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_half  = half;
    nxt_idle  = idle_cnt;
    frame_end = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (!half) begin
          nxt_half = 1'b1;
        end else begin
          nxt_half = 1'b0;
          if (phase == LAST_PHASE) begin
            frame_end = 1'b1;
            nxt_phase = 3'd0;
            nxt_idle  = '0;
            if (IDLE_PHASES > 0) begin
              nxt_state = ST_IDLE;
            end else begin
              nxt_state = scan_en ? ST_ACTIVE : ST_HOLD;
            end
          end else begin
            nxt_phase = phase + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (!half) begin
          nxt_half = 1'b1;
        end else begin
          nxt_half = 1'b0;
          if (idle_cnt == IDLE_LAST) begin
            nxt_idle  = '0;
            nxt_state = scan_en ? ST_ACTIVE : ST_HOLD;
          end else begin
            nxt_idle = idle_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // phase/half already sit at P0 half 0; just wait for enable
        if (scan_en) begin
          nxt_state = ST_ACTIVE;
        end
      end
      default: begin
        nxt_state = ST_ACTIVE;
        nxt_phase = 3'd0;
        nxt_half  = 1'b0;
        nxt_idle  = '0;
      end
    endcase

    // TH is high on even active phases and everywhere outside the active part
    nxt_mdsel = (nxt_state == ST_ACTIVE) ? ~nxt_phase[0] : 1'b1;
    nxt_split = (nxt_state == ST_ACTIVE) & nxt_half;
  end

  // Half-slot counter, state advance and registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_ACTIVE;
      phase       <= 3'd0;
      half        <= 1'b0;
      idle_cnt    <= '0;
      slot_cnt    <= '0;
      joy_mdsel   <= 1'b1;
      joy_split   <= 1'b0;
      pub_pending <= 1'b0;
    end else begin
      slot_cnt    <= slot_end ? '0 : slot_cnt + 1'b1;
      pub_pending <= slot_end & frame_end;
      if (slot_end) begin
        state     <= nxt_state;
        phase     <= nxt_phase;
        half      <= nxt_half;
        idle_cnt  <= nxt_idle;
        joy_mdsel <= nxt_mdsel;
        joy_split <= nxt_split;
      end
    end
  end

  // Decode the synchronized sample against the current phase for one port
  always_comb begin
    cur_btn = half ? w2_btn : w1_btn;
    cur_md  = half ? w2_md  : w1_md;
    cur_6b  = half ? w2_6b  : w1_6b;
    new_btn = cur_btn;
    new_md  = cur_md;
    new_6b  = cur_6b;
    case (phase)
      3'd0: begin
        // first TH-high read restarts the port: C,B,U,D,L,R, everything else clear
        new_btn = {6'd0, ~joy_s2};
        new_md  = 1'b0;
        new_6b  = 1'b0;
      end
      3'd1: begin
        // L/R forced low while TH is low marks a Megadrive pad; A/Start (or SMS
        // button 2 lines) are taken either way
        new_btn[6]  = ~joy_s2[4];
        new_btn[10] = ~joy_s2[5];
        new_md      = (joy_s2[1:0] == 2'b00);
      end
`ifdef JOY_DB9MD_6BTN_EN
      3'd5: begin
        // third TH-low read returns all-low directions only on a 6-button pad
        if (cur_md && (joy_s2[3:0] == 4'b0000)) begin
          new_6b = 1'b1;
        end
      end
      3'd6: begin
        // following TH-high read carries the extra buttons
        if (cur_6b) begin
          new_btn[11] = ~joy_s2[0];
          new_btn[7]  = ~joy_s2[1];
          new_btn[8]  = ~joy_s2[2];
          new_btn[9]  = ~joy_s2[3];
        end
      end
`endif
      default: begin
        // sequence-only phases: data ignored
      end
    endcase
  end

  // Working registers: half 0 samples port 1, half 1 samples port 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w1_btn <= 12'h000;
      w2_btn <= 12'h000;
      w1_md  <= 1'b0;
      w2_md  <= 1'b0;
      w1_6b  <= 1'b0;
      w2_6b  <= 1'b0;
    end else if (sample) begin
      if (half) begin
        w2_btn <= new_btn;
        w2_md  <= new_md;
        w2_6b  <= new_6b;
      end else begin
        w1_btn <= new_btn;
        w1_md  <= new_md;
        w1_6b  <= new_6b;
      end
    end
  end

  // Publish the completed frame as one atomic snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick1  <= 12'h000;
      joystick2  <= 12'h000;
      joy1_type  <= 2'b00;
      joy2_type  <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pub_pending;
      if (pub_pending) begin
        joystick1 <= w1_btn;
        joystick2 <= w2_btn;
        joy1_type <= {w1_6b, w1_md & ~w1_6b};
        joy2_type <= {w2_6b, w2_md & ~w2_6b};
      end
    end
  end

endmodule

// File: tb/tb_joy_db9md_scan.sv
// Bench for joy_db9md_scan: behavioural DB9 pads on both ports, expected
// snapshots queued as stimulus is applied and popped on each frame_done.
module tb_joy_db9md_scan;

  localparam int SLOT = 4;
  localparam int IDLE = 2;
`ifdef JOY_DB9MD_6BTN_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif
  localparam int FIRST  = NPH * 2 * SLOT + 1;
  localparam int PERIOD = (NPH + IDLE) * 2 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_en = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic [1:0]  joy1_type;
  logic [1:0]  joy2_type;
  logic        frame_done;

  always #5 clk = ~clk;

  joy_db9md_scan #(.SLOT_CYCLES(SLOT), .IDLE_PHASES(IDLE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_en    (scan_en),
    .joy_in     (joy_in),
    .joy_mdsel  (joy_mdsel),
    .joy_split  (joy_split),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy1_type  (joy1_type),
    .joy2_type  (joy2_type),
    .frame_done (frame_done)
  );

  // Pad configuration: kind 0 plain, 1 MD 3-button, 2 MD 6-button.
  // Held buttons use the output bit order {M,S,Z,Y,X,A,C,B,U,D,L,R}.
  int          kind1 = 0;
  int          kind2 = 0;
  logic [11:0] btn1 = 12'h000;
  logic [11:0] btn2 = 12'h000;

  // Shared TH-low counter of the pads, cleared after a long TH-high stretch.
  int   th_cnt = 0;
  int   hi_run = 0;
  logic prev_th = 1'b1;

  always @(negedge clk) begin
    prev_th <= joy_mdsel;
    if (joy_mdsel) hi_run <= hi_run + 1;
    else           hi_run <= 0;
    if (prev_th && !joy_mdsel) th_cnt <= th_cnt + 1;
    if (hi_run > 12) th_cnt <= 0;
  end

  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic th, input int n);
    logic [5:0] p;
    p = ~b[5:0];
    if (kind != 0 && !th) begin
      p = {~b[10], ~b[6], ~b[3], ~b[2], 2'b00};
      if (kind == 2 && n == 3)      p[3:0] = 4'b0000;
      else if (kind == 2 && n == 4) p[3:0] = 4'b1111;
    end else if (kind == 2 && th && n == 3) begin
      p = {~b[5], ~b[4], ~b[9], ~b[8], ~b[7], ~b[11]};
    end
    return p;
  endfunction

  always_comb begin
    joy_in = joy_split ? pad_pins(kind2, btn2, joy_mdsel, th_cnt)
                       : pad_pins(kind1, btn1, joy_mdsel, th_cnt);
  end

  // Expected decode of a pad as seen through the scan sequence.
  function automatic logic [13:0] port_exp(input int kind, input logic [11:0] b);
    logic [11:0] e;
    e = 12'h000;
    if (kind == 0) begin
      // static pins: B and C lines also read as A and Start under TH low
      e[5:0] = b[5:0];
      e[6]   = b[4];
      e[10]  = b[5];
      return {e, 2'b00};
    end
`ifdef JOY_DB9MD_6BTN_EN
    if (kind == 2) return {b, 2'b10};
`endif
    e = b & 12'h47F;
    return {e, 2'b01};
  endfunction

  typedef struct packed {
    logic [11:0] j1;
    logic [1:0]  t1;
    logic [11:0] j2;
    logic [1:0]  t2;
  } snap_t;

  snap_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp();
    logic [13:0] p1;
    logic [13:0] p2;
    snap_t s;
    p1 = port_exp(kind1, btn1);
    p2 = port_exp(kind2, btn2);
    s.j1 = p1[13:2];
    s.t1 = p1[1:0];
    s.j2 = p2[13:2];
    s.t2 = p2[1:0];
    sb_q.push_back(s);
  endtask

  // Wait for the next snapshot; outputs must not move before it arrives.
  task automatic wait_frame(input string tag, input int budget, output int cyc);
    logic [11:0] j1;
    logic [11:0] j2;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        seen;
    logic        moved;
    snap_t       s;
    j1 = joystick1; j2 = joystick2; t1 = joy1_type; t2 = joy2_type;
    seen = 1'b0; moved = 1'b0; cyc = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_done) seen = 1'b1;
      else if (joystick1 !== j1 || joystick2 !== j2 || joy1_type !== t1 || joy2_type !== t2)
        moved = 1'b1;
    end
    check_val({tag, "_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_hold"}, 32'(moved), 32'd0);
    if (seen) begin
      check_val({tag, "_sbq"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        check_val({tag, "_joy1"}, 32'(joystick1), 32'(s.j1));
        check_val({tag, "_type1"}, 32'(joy1_type), 32'(s.t1));
        check_val({tag, "_joy2"}, 32'(joystick2), 32'(s.j2));
        check_val({tag, "_type2"}, 32'(joy2_type), 32'(s.t2));
      end
    end
  endtask

  // Wait until TH reaches the given level, bounded.
  task automatic wait_th(input string tag, input logic level);
    int n;
    n = 0;
    while (joy_mdsel !== level && n < 4 * PERIOD) begin
      @(posedge clk); #1;
      n++;
    end
    if (joy_mdsel !== level) check_val({tag, "_th_timeout"}, 32'(joy_mdsel), 32'(level));
  endtask

  initial begin
    int   cyc;
    logic fd_seen;
    logic low_seen;
    logic split_seen;

    // reset values
    kind1 = 0; btn1 = 12'h001;
    kind2 = 0; btn2 = 12'h000;
    reset_n = 1'b0;
    scan_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_val("rst_mdsel", 32'(joy_mdsel), 32'd1);
    check_val("rst_split", 32'(joy_split), 32'd0);
    check_val("rst_joy1", 32'(joystick1), 32'h000);
    check_val("rst_joy2", 32'(joystick2), 32'h000);
    check_val("rst_type1", 32'(joy1_type), 32'd0);
    check_val("rst_type2", 32'(joy2_type), 32'd0);
    check_val("rst_fd", 32'(frame_done), 32'd0);

    // first frame: plain pad with R on port 1, idle plain pad on port 2
    push_exp();
    reset_n = 1'b1;
    wait_frame("f1", 4 * PERIOD, cyc);
    check_val("first_fd_cycle", 32'(cyc), 32'(FIRST));
    @(posedge clk); #1;
    check_val("fd_pulse_width", 32'(frame_done), 32'd0);

    // steady state frame period
    push_exp();
    wait_frame("f2", 4 * PERIOD, cyc);
    check_val("frame_period", 32'(cyc + 1), 32'(PERIOD));

    // 3-button pad on port 2, B + Start
    kind2 = 1; btn2 = 12'h410;
    push_exp();
    wait_frame("f3", 4 * PERIOD, cyc);

    // 6-button pad on port 1, Mode + Z
    kind1 = 2; btn1 = 12'hA00;
    push_exp();
    wait_frame("f4", 4 * PERIOD, cyc);

    // drop scan_en in P3: frame still publishes, then the scanner holds
    wait_th("p1", 1'b0);
    wait_th("p2", 1'b1);
    wait_th("p3", 1'b0);
    scan_en = 1'b0;
    push_exp();
    wait_frame("f5", 4 * PERIOD, cyc);
    fd_seen = 1'b0; low_seen = 1'b0; split_seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(posedge clk); #1;
      if (frame_done) fd_seen = 1'b1;
      if (!joy_mdsel) low_seen = 1'b1;
      if (joy_split)  split_seen = 1'b1;
    end
    check_val("hold_no_fd", 32'(fd_seen), 32'd0);
    check_val("hold_mdsel_high", 32'(low_seen), 32'd0);
    check_val("hold_split_low", 32'(split_seen), 32'd0);

    // re-raise: P0 begins at the next half-slot boundary, so port 2 is
    // selected between SLOT+1 and 2*SLOT cycles later
    kind1 = 0; btn1 = 12'h028;
    push_exp();
    scan_en = 1'b1;
    cyc = 0;
    while (!joy_split && cyc < 4 * SLOT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("restart_split_in_window", 32'(joy_split && cyc >= SLOT + 1 && cyc <= 2 * SLOT), 32'd1);
    check_val("restart_p0_mdsel", 32'(joy_mdsel), 32'd1);
    wait_frame("f6", 4 * PERIOD, cyc);

    // reset in the middle of the active part (P6 with the 6-button sequence)
`ifdef JOY_DB9MD_6BTN_EN
    wait_th("r1", 1'b0);
    wait_th("r2", 1'b1);
    wait_th("r3", 1'b0);
    wait_th("r4", 1'b1);
    wait_th("r5", 1'b0);
    wait_th("r6", 1'b1);
`else
    wait_th("r1", 1'b0);
    wait_th("r2", 1'b1);
`endif
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_joy1", 32'(joystick1), 32'h000);
    check_val("mid_rst_joy2", 32'(joystick2), 32'h000);
    check_val("mid_rst_type1", 32'(joy1_type), 32'd0);
    check_val("mid_rst_type2", 32'(joy2_type), 32'd0);
    check_val("mid_rst_mdsel", 32'(joy_mdsel), 32'd1);
    check_val("mid_rst_split", 32'(joy_split), 32'd0);
    kind1 = 2; btn1 = 12'hA00;
    repeat (20) @(posedge clk);
    #1;
    push_exp();
    reset_n = 1'b1;
    wait_frame("f7", 4 * PERIOD, cyc);
    check_val("restart_fd_cycle", 32'(cyc), 32'(FIRST));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
